mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipelined core.
- Serialises accesses and tolerates variable memory latency through a ready handshake.
- Produces stall signals for the IF and MEM stages, a bus timeout error, and fetch-response suppression on branch flush.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_timeout.sv | 34 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter.
//   state_t : arbiter FSM state (IDLE / BUSY / RESP)
//   owner_t : which requester owns the access in flight
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// bus_timeout_counter: counts cycles an access waits for mem_ready.
//   clk, reset_n : clock, async active-low reset
//   clear        : return count to zero
//   enable       : advance count by one
//   expired      : count has reached TIMEOUT_CYCLES-1 (always 0 when TIMEOUT_CYCLES=0)
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] cnt;

            assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

            // Saturates at the expiry value; the arbiter leaves BUSY on that edge.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)               cnt <= '0;
                else if (clear)             cnt <= '0;
                else if (enable && !expired) cnt <= cnt + CW'(1);
            end
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access. Data has priority. One access at a time: IDLE -> BUSY ->
// RESP -> IDLE, with a cycle budget on mem_ready.
//   if_*      : fetch requester (req/addr in, gnt/rvalid/rdata out)
//   flush_if  : cancels the response of an in-flight fetch
//   d_*       : data requester (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   mem_*     : registered memory request, mem_ready/mem_rdata back
//   stall_if, stall_mem : requester stalls
//   bus_err   : accompanies an rvalid produced by a timeout
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush_if,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    state_t state, state_nxt;
    owner_t owner;
    logic   flush_q;
    logic   if_rvalid_q, err_q;
    logic   take_d, take_if, done, tmo, tmo_expired;

    bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != BUSY),
        .enable  ((state == BUSY) && !mem_ready),
        .expired (tmo_expired)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and acceptance decisions
    always_comb begin
        take_d    = (state == IDLE) && d_req;
        take_if   = (state == IDLE) && !d_req && if_req && !flush_if;
        done      = (state == BUSY) && mem_ready;
        tmo       = (state == BUSY) && !mem_ready && tmo_expired;
        state_nxt = state;
        case (state)
            IDLE:    if (take_d || take_if) state_nxt = BUSY;
            BUSY:    if (done || tmo)       state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered datapath and response pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_gnt      <= 1'b0;
            d_gnt       <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid    <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            err_q       <= 1'b0;
            owner       <= OWN_DATA;
            flush_q     <= 1'b0;
        end else begin
            if_gnt      <= take_if;
            d_gnt       <= take_d;
            if_rvalid_q <= 1'b0;
            d_rvalid    <= 1'b0;
            err_q       <= 1'b0;

            if (take_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= d_wdata;
                owner     <= OWN_DATA;
            end else if (take_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                owner     <= OWN_FETCH;
            end

            if (done || tmo) begin
                mem_req <= 1'b0;
                if (owner == OWN_DATA) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= (tmo || mem_we) ? '0 : mem_rdata;
                    err_q    <= tmo;
                end else begin
                    // A fetch flushed before completion produces no response at all.
                    if_rvalid_q <= !(flush_q || flush_if);
                    if_rdata    <= tmo ? '0 : mem_rdata;
                    err_q       <= tmo && !(flush_q || flush_if);
                end
            end

            if (state == IDLE)
                flush_q <= 1'b0;
            else if (owner == OWN_FETCH && flush_if)
                flush_q <= 1'b1;
        end
    end

    // A flush arriving in the RESP cycle itself still kills the fetch response.
    always_comb begin
        if_rvalid = if_rvalid_q && !flush_if;
        bus_err   = err_q && !((owner == OWN_FETCH) && flush_if);
        stall_if  = if_req && !if_rvalid;
        stall_mem = d_req && !d_rvalid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int T = 4;

    logic        clk, reset_n;
    logic        if_req, flush_if, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem, bus_err;

    int checks = 0;
    int failures = 0;
    int mem_lat = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_A5A5;
    endfunction

    // Memory: ready after mem_lat waiting cycles; random noise when not requested.
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        mem_ready = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mem_ready = (lat_cnt >= mem_lat);
                mem_rdata = mem_ready ? mem_fn(mem_addr) : $urandom;
                lat_cnt++;
            end else begin
                lat_cnt = 0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    task automatic test_reset();
        reset_n = 0;
        if_req = 0; if_addr = 0; flush_if = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_gnt, d_gnt, if_rvalid, d_rvalid,
             if_rdata, d_rdata, bus_err, stall_if, stall_mem} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: mem_req=%b mem_addr=%h if_rdata=%h d_rdata=%h bus_err=%b, required all 0",
                     mem_req, mem_addr, if_rdata, d_rdata, bus_err);
        end
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int c;
        bit seen;
        mem_lat = 2;
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1 || mem_req !== 1 || mem_addr !== 32'h10 || mem_we !== 0) begin
            failures++;
            $display("FAIL fetch_gnt: gnt=%b req=%b addr=%h we=%b, required 1 1 00000010 0",
                     if_gnt, mem_req, mem_addr, mem_we);
        end
        seen = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk); c++;
            if (if_rvalid === 1) begin
                seen = 1;
                checks++;
                if (c != 3) begin failures++; $display("FAIL fetch_latency: %0d, required 3", c); end
                checks++;
                if (if_rdata !== 32'h0050_0093) begin
                    failures++; $display("FAIL fetch_rdata: %h, required 00500093", if_rdata);
                end
                checks++;
                if (stall_if !== 0) begin failures++; $display("FAIL fetch_stall: %b, required 0", stall_if); end
                if_req = 0;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL fetch_rvalid: not seen, required within 20 cycles"); end
        @(negedge clk);
    endtask

    task automatic test_priority();
        int c, dg, dv, ig, iv;
        mem_lat = 0;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        if_req = 1; if_addr = 32'h14;
        dg = -1; dv = -1; ig = -1; iv = -1;
        c = 0;
        while (c < 20 && iv < 0) begin
            @(negedge clk);
            if (d_gnt) dg = c;
            if (if_gnt) begin
                ig = c;
                checks++;
                if (mem_addr !== 32'h14) begin failures++; $display("FAIL prio_fetch_addr: %h, required 00000014", mem_addr); end
            end
            if (d_rvalid) begin
                dv = c;
                checks++;
                if (d_rdata !== mem_fn(32'h100)) begin
                    failures++; $display("FAIL prio_d_rdata: %h, required %h", d_rdata, mem_fn(32'h100));
                end
                d_req = 0;
            end
            checks++;
            if (stall_if !== (c < 4)) begin failures++; $display("FAIL prio_stall_if c=%0d: %b, required %b", c, stall_if, c < 4); end
            if (if_rvalid) begin
                iv = c;
                checks++;
                if (if_rdata !== mem_fn(32'h14)) begin
                    failures++; $display("FAIL prio_if_rdata: %h, required %h", if_rdata, mem_fn(32'h14));
                end
                if_req = 0;
            end
            c++;
        end
        checks++;
        if (dg != 0 || dv != 1 || ig != 3 || iv != 4) begin
            failures++;
            $display("FAIL prio_order: d_gnt=%0d d_rvalid=%0d if_gnt=%0d if_rvalid=%0d, required 0 1 3 4", dg, dv, ig, iv);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int c, hi;
        bit seen;
        mem_lat = 99;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        seen = 0; hi = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            if (mem_req === 1) hi++;
            if (d_rvalid === 1) begin
                seen = 1;
                checks++;
                if (hi != T || c != T) begin failures++; $display("FAIL tmo_req_cycles: high=%0d at=%0d, required %0d", hi, c, T); end
                checks++;
                if (bus_err !== 1 || d_rdata !== 0 || mem_req !== 0) begin
                    failures++; $display("FAIL tmo_resp: bus_err=%b d_rdata=%h mem_req=%b, required 1 0 0", bus_err, d_rdata, mem_req);
                end
                d_req = 0;
            end
            c++;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL tmo_rvalid: not seen, required at cycle %0d", T); end
        @(negedge clk);
        mem_lat = 1;
        d_req = 1; d_addr = 32'h304;
        seen = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk); c++;
            if (d_rvalid === 1) begin
                seen = 1;
                checks++;
                if (bus_err !== 0 || d_rdata !== mem_fn(32'h304)) begin
                    failures++; $display("FAIL tmo_next: bus_err=%b d_rdata=%h, required 0 %h", bus_err, d_rdata, mem_fn(32'h304));
                end
                d_req = 0;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL tmo_next_rvalid: not seen"); end
        @(negedge clk);
    endtask

    task automatic test_store();
        int c;
        bit seen;
        mem_lat = int'($urandom_range(0, 3));
        d_req = 1; d_we = 1; d_addr = 32'h203; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1 || mem_addr !== 32'h200 || mem_we !== 1 || mem_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_gnt: gnt=%b addr=%h we=%b wdata=%h, required 1 00000200 1 deadbeef",
                     d_gnt, mem_addr, mem_we, mem_wdata);
        end
        seen = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk); c++;
            if (d_rvalid === 1) begin
                seen = 1;
                checks++;
                if (d_rdata !== 0 || bus_err !== 0 || c != mem_lat + 1) begin
                    failures++; $display("FAIL store_resp: d_rdata=%h bus_err=%b lat=%0d, required 0 0 %0d", d_rdata, bus_err, c, mem_lat + 1);
                end
                d_req = 0; d_we = 0;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL store_rvalid: not seen"); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int c, bad;
        bit found, seen;
        mem_lat = 2;
        if_req = 1; if_addr = 32'h30; flush_if = 1;
        @(negedge clk);
        checks++;
        if (if_gnt !== 0 || mem_req !== 0) begin
            failures++; $display("FAIL flush_idle_block: gnt=%b req=%b, required 0 0", if_gnt, mem_req);
        end
        flush_if = 0;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1 || mem_addr !== 32'h30) begin
            failures++; $display("FAIL flush_first_gnt: gnt=%b addr=%h, required 1 00000030", if_gnt, mem_addr);
        end
        @(negedge clk);
        flush_if = 1; if_addr = 32'h40;
        @(negedge clk);
        flush_if = 0;
        bad = 0; found = 0; c = 0;
        while (!found && c < 20) begin
            if (if_rvalid === 1 || bus_err === 1) bad++;
            if (if_gnt === 1) begin
                found = 1;
                checks++;
                if (mem_addr !== 32'h40) begin failures++; $display("FAIL flush_target_addr: %h, required 00000040", mem_addr); end
            end else begin
                @(negedge clk); c++;
            end
        end
        checks++;
        if (bad != 0 || !found) begin
            failures++; $display("FAIL flush_suppress: stray_resp=%0d new_gnt=%b, required 0 1", bad, found);
        end
        seen = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk); c++;
            if (if_rvalid === 1) begin
                seen = 1;
                checks++;
                if (if_rdata !== mem_fn(32'h40)) begin failures++; $display("FAIL flush_target_rdata: %h, required %h", if_rdata, mem_fn(32'h40)); end
                if_req = 0;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL flush_target_rvalid: not seen"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c, stale;
        bit seen;
        mem_lat = 99;
        d_req = 1; d_we = 0; d_addr = 32'h500;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_gnt, d_gnt, if_rvalid, d_rvalid,
             if_rdata, d_rdata, bus_err} !== '0) begin
            failures++; $display("FAIL reset_mid_outputs: mem_req=%b mem_addr=%h d_rdata=%h, required all 0", mem_req, mem_addr, d_rdata);
        end
        d_req = 0;
        mem_lat = 0;
        @(negedge clk);
        reset_n = 1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_rvalid || if_rvalid || bus_err || mem_req || d_gnt || if_gnt) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL reset_mid_stale: %0d cycles with activity, required 0", stale); end
        if_req = 1; if_addr = 32'h44;
        seen = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk); c++;
            if (if_rvalid === 1) begin
                seen = 1;
                checks++;
                if (if_rdata !== mem_fn(32'h44) || c != 2) begin
                    failures++; $display("FAIL reset_mid_fetch: rdata=%h lat=%0d, required %h 2", if_rdata, c, mem_fn(32'h44));
                end
                if_req = 0;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL reset_mid_rvalid: not seen"); end
        @(negedge clk);
    endtask

    // Random traffic against a transaction-level model: data beats fetch,
    // each access answers after lat+1 cycles or T cycles on timeout.
    task automatic test_random();
        for (int it = 0; it < 150; it++) begin
            int scen, lat, c, dg, ig, exp_lat;
            bit d_act, i_act, d_done, i_done, tmo;
            logic [31:0] da, dw, ia;
            logic we;
            scen = int'($urandom_range(0, 2));
            lat  = int'($urandom_range(0, 5));
            tmo  = (lat >= T);
            exp_lat = tmo ? T : lat + 1;
            da = $urandom; dw = $urandom; ia = $urandom; we = 1'($urandom_range(0, 1));
            d_act = (scen != 1); i_act = (scen != 0);
            d_done = !d_act; i_done = !i_act;
            dg = -1; ig = -1;
            mem_lat = lat;
            d_req = d_act; d_we = we; d_addr = da; d_wdata = dw;
            if_req = i_act; if_addr = ia;
            c = 0;
            while (!(d_done && i_done) && c < 40) begin
                @(negedge clk);
                checks++;
                if (stall_if !== (if_req & ~if_rvalid) || stall_mem !== (d_req & ~d_rvalid)) begin
                    failures++; $display("FAIL rnd_stall it=%0d: if=%b mem=%b", it, stall_if, stall_mem);
                end
                if (d_gnt) begin
                    dg = c;
                    checks++;
                    if (!d_act || mem_addr !== {da[31:2], 2'b00} || mem_we !== we || (we && mem_wdata !== dw)) begin
                        failures++; $display("FAIL rnd_d_gnt it=%0d: addr=%h we=%b wdata=%h, required %h %b %h",
                                             it, mem_addr, mem_we, mem_wdata, {da[31:2], 2'b00}, we, dw);
                    end
                end
                if (if_gnt) begin
                    ig = c;
                    checks++;
                    if (!i_act || !d_done || mem_addr !== {ia[31:2], 2'b00} || mem_we !== 0) begin
                        failures++; $display("FAIL rnd_if_gnt it=%0d: addr=%h we=%b data_done=%b, required %h 0 1",
                                             it, mem_addr, mem_we, d_done, {ia[31:2], 2'b00});
                    end
                end
                if (d_rvalid) begin
                    logic [31:0] exp_d;
                    exp_d = (we || tmo) ? 32'h0 : mem_fn({da[31:2], 2'b00});
                    checks++;
                    if (dg < 0 || c - dg != exp_lat || d_rdata !== exp_d || bus_err !== tmo) begin
                        failures++; $display("FAIL rnd_d_resp it=%0d: lat=%0d rdata=%h err=%b, required %0d %h %b",
                                             it, c - dg, d_rdata, bus_err, exp_lat, exp_d, tmo);
                    end
                    d_req = 0; d_done = 1;
                end
                if (if_rvalid) begin
                    logic [31:0] exp_i;
                    exp_i = tmo ? 32'h0 : mem_fn({ia[31:2], 2'b00});
                    checks++;
                    if (ig < 0 || c - ig != exp_lat || if_rdata !== exp_i || bus_err !== tmo) begin
                        failures++; $display("FAIL rnd_if_resp it=%0d: lat=%0d rdata=%h err=%b, required %0d %h %b",
                                             it, c - ig, if_rdata, bus_err, exp_lat, exp_i, tmo);
                    end
                    if_req = 0; i_done = 1;
                end
                if (!d_rvalid && !if_rvalid && bus_err !== 0) begin
                    checks++; failures++; $display("FAIL rnd_stray_err it=%0d: bus_err=%b, required 0", it, bus_err);
                end
                c++;
            end
            checks++;
            if (!(d_done && i_done)) begin
                failures++; $display("FAIL rnd_complete it=%0d: data_done=%b fetch_done=%b, required 1 1", it, d_done, i_done);
                d_req = 0; if_req = 0;
                repeat (10) @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_timeout();
        test_store();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
